team_06_i2s_adc_receiver: RTL and testbench
===========================================

// Module: team_06_i2s_adc_receiver
// PURPOSE
//  I2S master-mode receiver for an 8-bit serial ADC. It generates the bit clock (i2sclk) and the
//  word select (ws) from the system clock. It deserializes MSB-first two's-complement samples into
//  a parallel byte and flags each completed sample. It sits between the ADC pins and the audio
//  datapath; the sample word is signed 8-bit, and the block treats it as raw bits.
// PARAMETERS
//  CLK_DIV    4   system-clock cycles per i2sclk half-period (i2sclk = clk / (2*CLK_DIV)); >=2
//  DATA_BITS  8   sample width captured per slot
//  SLOT_BITS  32  i2sclk periods per ws half (one channel slot); must be > DATA_BITS
// PORTS
//  clk               input   1          system clock; all state updates on its rising edge
//  rst               input   1          reset, asynchronous, active-high
//  adc_serial_in     input   1          serial data from ADC; sender drives on i2sclk fall
//  i2s_parallel_out  output  DATA_BITS  last completed sample, MSB = first bit received
//  finished          output  1          1-clk pulse when i2s_parallel_out updates
//  ws                output  1          word select (0 = left slot, 1 = right slot)
//  i2sclk            output  1          generated I2S bit clock, registered
// BEHAVIOUR
//  Reset (async, rst=1): every register clears.
//   - Outputs: i2sclk=0, ws=0, i2s_parallel_out=0, finished=0.
//   - Internal: div counter=0, bit_cnt=0, shift reg=0.
//   - Reset mid-word discards the partial sample. Bit timing restarts from zero after release.
//  Divider:
//   - The div counter counts 0..CLK_DIV-1 on clk.
//   - At CLK_DIV-1 the counter wraps to 0 and i2sclk toggles.
//   - First i2sclk rise occurs at the CLK_DIV-th clk edge after rst falls.
//   - The toggle cycle raises an internal one-clk strobe: rise_tick (0->1) or fall_tick (1->0).
//   - All I2S logic is synchronous to clk and gated by these strobes. No logic is clocked by i2sclk.
//  Slot counter (fall_tick):
//   - bit_cnt increments.
//   - When bit_cnt==SLOT_BITS-1: bit_cnt wraps to 0 and ws toggles.
//   - Result: ws period = 2*SLOT_BITS i2sclk periods; ws changes only on i2sclk falling edges.
//  Capture (rise_tick), standard I2S one-bit delay:
//   - Slot bit index 0 (the period in which ws just changed) is ignored.
//   - Indices 1..DATA_BITS: adc_serial_in shifts into the LSB of the shift register (shift left).
//   - On the rise_tick with bit_cnt==DATA_BITS: i2s_parallel_out <= {shift[DATA_BITS-2:0], adc_serial_in}.
//     finished=1 for exactly that one clk; otherwise finished=0.
//   - Indices DATA_BITS+1..SLOT_BITS-1 are ignored (padding).
//   - Both slots (ws=0 and ws=1) are captured identically. The consumer reads ws to know the channel.
//  Output stability:
//   - i2s_parallel_out holds its value until the next completed sample.
//   - The shift register clears at bit index 0 of each slot.
//  Boundary:
//   - Values 0x80 (-128), 0xFF (-1) and 0x7F (127) pass bit-exact; there is no sign handling.
//   - The first slot after reset has ws=0 and is captured normally.
// TESTING (clk period 20 ns, defaults; drive adc_serial_in on i2sclk fall)
//  1. Release rst -> i2sclk toggles every 4 clk (period 160 ns); first rise 4 clk after release.
//  2. Free run -> ws toggles on an i2sclk fall every 32 i2sclk periods.
//     finished pulses once per slot, 1 clk wide.
//  3. After a ws edge, send the delay bit, then 1,0,1,0,0,1,1,1 -> i2s_parallel_out=0xA7 at the 8th
//     data rise, with finished=1. Trailing padding bits do not change the output.
//  4. Next slot data 0xFF -> 0xFF; then 0x80 -> 0x80; then 0x7F -> 0x7F.
//     Check the ws value at each capture alternates.
//  5. Assert rst after 4 data bits -> all outputs return to 0 immediately (async).
//     After release, the next full slot captures correctly (e.g. 0xD6).
//  6. Hold adc_serial_in=0 -> 0x00 captured each slot, finished still pulses.

Source files
------------

// File: rtl/team_06_i2s_adc_receiver.sv
// team_06_i2s_adc_receiver: I2S master receiver that generates i2sclk/ws and deserializes MSB-first ADC samples
module team_06_i2s_adc_receiver #(
    parameter int CLK_DIV   = 4,
    parameter int DATA_BITS = 8,
    parameter int SLOT_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 adc_serial_in,
    output logic [DATA_BITS-1:0] i2s_parallel_out,
    output logic                 finished,
    output logic                 ws,
    output logic                 i2sclk
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(SLOT_BITS);

    logic [DW-1:0]        div;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 wrap, rise_tick, fall_tick, slot_end, last_bit;

    assign wrap      = div == DW'(CLK_DIV - 1);
    assign rise_tick = wrap & ~i2sclk;
    assign fall_tick = wrap & i2sclk;
    assign slot_end  = bit_cnt == BW'(SLOT_BITS - 1);
    assign last_bit  = bit_cnt == BW'(DATA_BITS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div              <= '0;
            i2sclk           <= 1'b0;
            ws               <= 1'b0;
            bit_cnt          <= '0;
            shift            <= '0;
            i2s_parallel_out <= '0;
            finished         <= 1'b0;
        end else begin
            div      <= wrap ? '0 : div + 1'b1;
            i2sclk   <= wrap ? ~i2sclk : i2sclk;
            finished <= rise_tick & last_bit;
            if (fall_tick) begin
                bit_cnt <= slot_end ? '0 : bit_cnt + 1'b1;
                ws      <= slot_end ? ~ws : ws;
            end
            // bit index 0 is the I2S one-bit delay after ws changes
            if (rise_tick) begin
                if (bit_cnt == '0)
                    shift <= '0;
                else if (bit_cnt <= BW'(DATA_BITS))
                    shift <= {shift[DATA_BITS-2:0], adc_serial_in};
                if (last_bit)
                    i2s_parallel_out <= {shift[DATA_BITS-2:0], adc_serial_in};
            end
        end
    end
endmodule

// File: tb/tb_team_06_i2s_adc_receiver.sv
// tb_team_06_i2s_adc_receiver: randomized self-checking bench with a cycle-count reference model
module tb_team_06_i2s_adc_receiver;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       adc_serial_in = 1'b0;
    logic [7:0] i2s_parallel_out;
    logic       finished, ws, i2sclk;

    int         checks = 0;
    int         errors = 0;
    int         c = 0;
    logic [7:0] exp_out = 8'h00;
    logic [7:0] samp [0:7];

    team_06_i2s_adc_receiver dut (
        .clk(clk), .rst(rst), .adc_serial_in(adc_serial_in),
        .i2s_parallel_out(i2s_parallel_out), .finished(finished),
        .ws(ws), .i2sclk(i2sclk)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s c=%0d observed=%h expected=%h", tag, c, obs, expv);
        end
    endtask

    // c = clk rises since reset release; each i2sclk period is 8 clk, each slot 32 periods
    task automatic step();
        int k;
        logic [7:0] s;
        @(posedge clk);
        c++;
        @(negedge clk);
        if (c % 256 == 68) exp_out = samp[(c / 256) % 8];
        chk("i2sclk", {7'b0, i2sclk}, {7'b0, 1'((c / 4) % 2)});
        chk("ws", {7'b0, ws}, {7'b0, 1'((c / 256) % 2)});
        chk("finished", {7'b0, finished}, {7'b0, c % 256 == 68});
        chk("data", i2s_parallel_out, exp_out);
        k = (c / 8) % 32;
        s = samp[(c / 256) % 8];
        adc_serial_in = (k >= 1 && k <= 8) ? s[8 - k] : 1'($urandom);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_i2sclk"}, {7'b0, i2sclk}, 8'h00);
        chk({tag, "_ws"}, {7'b0, ws}, 8'h00);
        chk({tag, "_finished"}, {7'b0, finished}, 8'h00);
        chk({tag, "_data"}, i2s_parallel_out, 8'h00);
    endtask

    initial begin
        samp[0] = 8'hA7; samp[1] = 8'hFF; samp[2] = 8'h80; samp[3] = 8'h7F;
        for (int i = 4; i < 8; i++) samp[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        c = 0;
        repeat (8 * 256) step();
        // reset after four data bits of the next slot
        while (c % 256 != 40) step();
        rst = 1'b1;
        #1 check_zero("async_rst");
        repeat (2) @(negedge clk);
        check_zero("rst_hold");
        samp[0] = 8'hD6;
        for (int i = 1; i < 8; i++) samp[i] = 8'($urandom);
        exp_out = 8'h00;
        rst = 1'b0;
        c = 0;
        repeat (4 * 256) step();
        for (int i = 0; i < 8; i++) samp[i] = 8'h00;
        repeat (3 * 256) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
